// File: rtl/seven_seg_readback.sv
// Receive side of the multiplexed 7-segment bus: syncs segment/anode pins, waits for a stable
// pattern, and decodes it back to a BCD digit per display position with validity ageing.
module seven_seg_readback #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    seg_in,
  input  logic [N_DIGITS-1:0]           an_in,
  output logic [4*N_DIGITS-1:0]         digits_out,
  output logic [N_DIGITS-1:0]           dp_out,
  output logic [N_DIGITS-1:0]           digit_valid,
  output logic [N_DIGITS-1:0]           digit_err,
  output logic                          upd_stb,
  output logic [$clog2(N_DIGITS)-1:0]   upd_idx
);

  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam int unsigned AW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SW = N_DIGITS + 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              seg_s1_q, seg_s2_q;
  logic [N_DIGITS-1:0]     an_s1_q, an_s2_q;
  logic [SW-1:0]           samp_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0]   digits_q, digits_d;
  logic [N_DIGITS-1:0]     dp_q, dp_d, valid_q, valid_d, err_q, err_d;
  logic                    upd_stb_q, upd_stb_d;
  logic [IW-1:0]           upd_idx_q, upd_idx_d;
  logic [AW-1:0]           age_q [N_DIGITS];
  logic [AW-1:0]           age_d [N_DIGITS];

  logic                    changed, one_hot, capture, dec_err, dp_lit;
  logic [N_DIGITS-1:0]     an_low;
  logic [IW-1:0]           cap_idx;
  logic [3:0]              dec_digit;

  // Stability tracking and pattern decode
  always_comb begin
    changed = ({an_s2_q, seg_s2_q} != samp_q);
    an_low  = ~an_s2_q;
    one_hot = (an_low != '0) && ((an_low & (an_low - N_DIGITS'(1))) == '0);
    cnt_d   = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));

    cap_idx = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!samp_q[8+i]) cap_idx = IW'(i);
    end

    dp_lit  = ~samp_q[0];
    dec_err = 1'b0;
    case (samp_q[7:1])
      7'h01:   dec_digit = 4'd0;
      7'h4F:   dec_digit = 4'd1;
      7'h12:   dec_digit = 4'd2;
      7'h06:   dec_digit = 4'd3;
      7'h4C:   dec_digit = 4'd4;
      7'h24:   dec_digit = 4'd5;
      7'h60:   dec_digit = 4'd6;
      7'h0F:   dec_digit = 4'd7;
      7'h00:   dec_digit = 4'd8;
      7'h0C:   dec_digit = 4'd9;
      default: begin
        dec_digit = 4'hF;
        dec_err   = 1'b1;
      end
    endcase
  end

  // A capture coinciding with a new synced pattern must not park in HOLD, or the
  // new pattern would never be seen as a change.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) state_d = TRACK;
      end
      TRACK: begin
        if (cnt_q == CNT_MAX) begin
          capture = 1'b1;
          if (changed) state_d = one_hot ? TRACK : IDLE;
          else         state_d = HOLD;
        end else if (!one_hot) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (changed) state_d = one_hot ? TRACK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    digits_d  = digits_q;
    dp_d      = dp_q;
    err_d     = err_q;
    valid_d   = valid_q;
    upd_stb_d = 1'b0;
    upd_idx_d = upd_idx_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AW'(1);
      if (age_q[i] == AGE_MAX) valid_d[i] = 1'b0;
    end
    if (capture) begin
      if ((digits_q[cap_idx*4 +: 4] != dec_digit) || (dp_q[cap_idx] != dp_lit) ||
          (err_q[cap_idx] != dec_err) || !valid_q[cap_idx]) begin
        upd_stb_d = 1'b1;
        upd_idx_d = cap_idx;
      end
      digits_d[cap_idx*4 +: 4] = dec_digit;
      dp_d[cap_idx]            = dp_lit;
      err_d[cap_idx]           = dec_err;
      valid_d[cap_idx]         = 1'b1;
      age_d[cap_idx]           = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seg_s1_q  <= '1;
      seg_s2_q  <= '1;
      an_s1_q   <= '1;
      an_s2_q   <= '1;
      samp_q    <= '1;
      cnt_q     <= '0;
      digits_q  <= '0;
      dp_q      <= '0;
      err_q     <= '0;
      valid_q   <= '0;
      upd_stb_q <= 1'b0;
      upd_idx_q <= '0;
      for (int unsigned i = 0; i < N_DIGITS; i++) age_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      seg_s1_q  <= seg_in;
      seg_s2_q  <= seg_s1_q;
      an_s1_q   <= an_in;
      an_s2_q   <= an_s1_q;
      samp_q    <= {an_s2_q, seg_s2_q};
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      upd_stb_q <= upd_stb_d;
      upd_idx_q <= upd_idx_d;
      for (int unsigned i = 0; i < N_DIGITS; i++) age_q[i] <= age_d[i];
    end
  end

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign upd_stb     = upd_stb_q;
  assign upd_idx     = upd_idx_q;

endmodule
